// File: rtl/cordic_atan_seq.sv
// cordic_atan_seq: arctangent constant source for the CORDIC vectoring datapath.
// Sequenced angle stream plus independent registered read port; define CORDIC_ATAN_ROUND_EN for round-half-up entries.
module cordic_atan_seq #(
    parameter int WORD_LENGTH = 16,
    parameter int ITERATIONS  = 16,
    parameter int IDX_W       = $clog2(ITERATIONS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   advance,
    output logic [WORD_LENGTH-1:0] angle,
    output logic [IDX_W-1:0]       index,
    output logic                   valid,
    output logic                   last,
    output logic                   busy,
    input  logic                   rd_en,
    input  logic [IDX_W-1:0]       rd_addr,
    output logic [WORD_LENGTH-1:0] rd_data,
    output logic                   rd_valid
);
    // Handshake: the entry on angle/index is live while valid=1 and is consumed on a rising
    // edge where advance=1; start (re)loads entry 0 and wins over advance in the same cycle.

    // floor(atan(2^-k) / (2*pi) * 2^32), k = 0..31
    localparam logic [31:0] ATAN_TABLE [32] = '{
        32'h20000000, 32'h12E4051D, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2E, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2F9, 32'h0000517C,
        32'h000028BE, 32'h0000145F, 32'h00000A2F, 32'h00000517,
        32'h0000028B, 32'h00000145, 32'h000000A2, 32'h00000051,
        32'h00000028, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000002, 32'h00000001, 32'h00000000, 32'h00000000
    };

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITERATIONS - 1);

`ifdef CORDIC_ATAN_ROUND_EN
    localparam int          HALF_SH = (WORD_LENGTH < 32) ? 31 - WORD_LENGTH : 0;
    localparam logic [32:0] HALF    = (WORD_LENGTH < 32) ? (33'd1 << HALF_SH) : 33'd0;

    function automatic logic [WORD_LENGTH-1:0] entry(input logic [4:0] k);
        logic [32:0] sum;
        sum = {1'b0, ATAN_TABLE[k]} + HALF;
        if (sum[32]) return '1;
        return WORD_LENGTH'(sum >> (32 - WORD_LENGTH));
    endfunction
`else
    function automatic logic [WORD_LENGTH-1:0] entry(input logic [4:0] k);
        return WORD_LENGTH'(ATAN_TABLE[k] >> (32 - WORD_LENGTH));
    endfunction
`endif

    typedef enum logic {IDLE, RUN} state_t;
    state_t state;

    logic [IDX_W-1:0]       idx_next;
    logic [WORD_LENGTH-1:0] angle_next;

    assign idx_next   = index + 1'b1;
    assign angle_next = entry(5'(idx_next));
    assign busy       = valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            index <= '0;
            angle <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (start) begin
            state <= RUN;
            index <= '0;
            angle <= entry(5'd0);
            valid <= 1'b1;
            last  <= 1'b0;
        end else if (state == RUN && advance) begin
            if (last) begin
                state <= IDLE;
                index <= '0;
                angle <= '0;
                valid <= 1'b0;
                last  <= 1'b0;
            end else begin
                index <= idx_next;
                angle <= angle_next;
                last  <= (idx_next == LAST_IDX);
            end
        end
    end

    // Read port runs independently of the sequencer; out-of-range addresses read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= (int'(rd_addr) < ITERATIONS) ? entry(5'(rd_addr)) : '0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_atan_seq.sv
// tb_cordic_atan_seq: directed vectors and randomized traffic for cordic_atan_seq,
// checked against an arctangent model evaluated with real arithmetic.
module tb_cordic_atan_seq;

    localparam int W  = 16;
    localparam int N  = 16;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main instance, W=16 N=16
    logic          start, advance, rd_en;
    logic [IW-1:0] rd_addr;
    logic [W-1:0]  angle, rd_data;
    logic [IW-1:0] index;
    logic          valid, last, busy, rd_valid;

    // W=16 N=12 instance for out-of-range reads
    logic          b_rd_en;
    logic [3:0]    b_rd_addr, b_index;
    logic [15:0]   b_angle, b_rd_data;
    logic          b_valid, b_last, b_busy, b_rd_valid;

    // W=24 N=24 instance for width scaling
    logic          c_rd_en;
    logic [4:0]    c_rd_addr, c_index;
    logic [23:0]   c_angle, c_rd_data;
    logic          c_valid, c_last, c_busy, c_rd_valid;

    cordic_atan_seq #(.WORD_LENGTH(W), .ITERATIONS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .advance(advance),
        .angle(angle), .index(index), .valid(valid), .last(last), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    cordic_atan_seq #(.WORD_LENGTH(16), .ITERATIONS(12)) dut_b (
        .clk(clk), .rst(rst), .start(1'b0), .advance(1'b0),
        .angle(b_angle), .index(b_index), .valid(b_valid), .last(b_last), .busy(b_busy),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
    );

    cordic_atan_seq #(.WORD_LENGTH(24), .ITERATIONS(24)) dut_c (
        .clk(clk), .rst(rst), .start(1'b0), .advance(1'b0),
        .angle(c_angle), .index(c_index), .valid(c_valid), .last(c_last), .busy(c_busy),
        .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_valid(c_rd_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_seq(input string name, input logic v, input int idx,
                             input longint ang, input logic l);
        check({name, ".valid"}, longint'(valid), longint'(v));
        check({name, ".busy"},  longint'(busy),  longint'(v));
        check({name, ".index"}, longint'(index), longint'(idx));
        check({name, ".angle"}, longint'(angle), ang);
        check({name, ".last"},  longint'(last),  longint'(l));
    endtask

    // Reference: the angle itself, in binary angle units, from the real-valued arctangent.
    function automatic longint ref_entry(input int k, input int w, input int n);
        real    ang, c;
        longint ci, e;
        if (k >= n) return 0;
        ang = $atan(1.0 / (2.0 ** k));
        // small bias so the exact 45-degree value does not floor one below
        c  = $floor(ang / (8.0 * $atan(1.0)) * 4294967296.0 + 1.0e-6);
        ci = longint'(c);
`ifdef CORDIC_ATAN_ROUND_EN
        e = (ci + (longint'(1) << (31 - w))) >> (32 - w);
        if (e > (longint'(1) << w) - 1) e = (longint'(1) << w) - 1;
`else
        e = ci >> (32 - w);
`endif
        return e;
    endfunction

    typedef struct {
        logic        adv;
        int          idx;
        logic [15:0] angle;
        logic        last;
    } seq_vec_t;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } rd_vec_t;

`ifdef CORDIC_ATAN_ROUND_EN
    localparam logic [15:0] SEQ_ANGLES [16] = '{
        16'h2000, 16'h12E4, 16'h09FB, 16'h0511, 16'h028B, 16'h0146, 16'h00A3, 16'h0051,
        16'h0029, 16'h0014, 16'h000A, 16'h0005, 16'h0003, 16'h0001, 16'h0001, 16'h0000
    };
`else
    localparam logic [15:0] SEQ_ANGLES [16] = '{
        16'h2000, 16'h12E4, 16'h09FB, 16'h0511, 16'h028B, 16'h0145, 16'h00A2, 16'h0051,
        16'h0028, 16'h0014, 16'h000A, 16'h0005, 16'h0002, 16'h0001, 16'h0000, 16'h0000
    };
`endif

    seq_vec_t    seq_tbl [16];
    rd_vec_t     rd_tbl [3];
    logic [31:0] exp_q[$];
    logic [31:0] c_exp_q[$];

    initial begin
        int     pos;
        longint last_rd, c_last_rd;
        logic   exp_rv, c_exp_rv;
        logic [31:0] e;

        for (int i = 0; i < 16; i++) begin
            seq_tbl[i].adv   = 1'b1;
            seq_tbl[i].idx   = i;
            seq_tbl[i].angle = SEQ_ANGLES[i];
            seq_tbl[i].last  = (i == 15);
        end
        rd_tbl[0] = '{addr: 1,  data: 16'h12E4};
        rd_tbl[1] = '{addr: 15, data: 16'h0000};
        rd_tbl[2] = '{addr: 2,  data: 16'h09FB};

        rst = 1'b1; start = 0; advance = 0; rd_en = 0; rd_addr = '0;
        b_rd_en = 0; b_rd_addr = '0; c_rd_en = 0; c_rd_addr = '0;

        // reset state
        #1;
        check_seq("reset", 1'b0, 0, 0, 1'b0);
        check("reset.rd_data", longint'(rd_data), 0);
        check("reset.rd_valid", longint'(rd_valid), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // advance while idle is ignored
        advance = 1'b1;
        @(negedge clk); @(negedge clk);
        check_seq("idle_adv", 1'b0, 0, 0, 1'b0);

        // full sequence, advance held high after start
        start = 1'b1; advance = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            advance = seq_tbl[i].adv;
            check_seq("full", 1'b1, seq_tbl[i].idx, longint'(seq_tbl[i].angle), seq_tbl[i].last);
            @(negedge clk);
        end
        check_seq("full_end", 1'b0, 0, 0, 1'b0);
        advance = 1'b0;

        // stall at index 3, then start+advance together restarts at 0
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; advance = 1'b1;
        repeat (3) @(negedge clk);
        advance = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_seq("stall", 1'b1, 3, longint'(SEQ_ANGLES[3]), 1'b0);
            @(negedge clk);
        end
        start = 1'b1; advance = 1'b1;
        @(negedge clk);
        start = 1'b0; advance = 1'b0;
        check_seq("restart", 1'b1, 0, longint'(SEQ_ANGLES[0]), 1'b0);
        @(negedge clk);
        check_seq("restart_hold", 1'b1, 0, longint'(SEQ_ANGLES[0]), 1'b0);

        // random access: three back-to-back reads, then hold; N=12 out-of-range read
        rd_en = 1'b1; rd_addr = IW'(rd_tbl[0].addr);
        b_rd_en = 1'b1; b_rd_addr = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rd.valid", longint'(rd_valid), 1);
            check("rd.data", longint'(rd_data), longint'(rd_tbl[i].data));
            if (i == 0) begin
                check("rd_n12.addr0", longint'(b_rd_data), 64'h2000);
                b_rd_addr = 4'd13;
            end else if (i == 1) begin
                check("rd_n12.addr13", longint'(b_rd_data), 0);
                b_rd_en = 1'b0;
            end
            if (i < 2) rd_addr = IW'(rd_tbl[i + 1].addr);
            else rd_en = 1'b0;
        end
        @(negedge clk);
        check("rd_idle.valid", longint'(rd_valid), 0);
        check("rd_idle.hold", longint'(rd_data), 64'h09FB);

        // reset mid-sequence at index 5 clears outputs without a clock edge
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; advance = 1'b1;
        repeat (5) @(negedge clk);
        advance = 1'b0;
        check_seq("pre_reset", 1'b1, 5, longint'(SEQ_ANGLES[5]), 1'b0);
        #2 rst = 1'b1;
        #1;
        check_seq("async_reset", 1'b0, 0, 0, 1'b0);
        check("async_reset.rd_data", longint'(rd_data), 0);
        @(negedge clk);
        rst = 1'b0;
        advance = 1'b1;
        repeat (3) @(negedge clk);
        advance = 1'b0;
        check_seq("post_reset_adv", 1'b0, 0, 0, 1'b0);

        // width scaling: W=24 reads of entries 0, 1 and 23
        c_rd_en = 1'b1; c_rd_addr = 5'd0;
        @(negedge clk);
        check("w24.entry0", longint'(c_rd_data), 64'h200000);
        check("w24.entry0_model", longint'(c_rd_data), ref_entry(0, 24, 24));
        c_rd_addr = 5'd1;
        @(negedge clk);
        check("w24.entry1", longint'(c_rd_data), ref_entry(1, 24, 24));
        c_rd_addr = 5'd23;
        @(negedge clk);
        check("w24.entry23", longint'(c_rd_data), ref_entry(23, 24, 24));
        c_rd_en = 1'b0;
        @(negedge clk);

        // randomized traffic on both ports against the reference model
        pos = -1;
        last_rd = longint'(rd_data); c_last_rd = longint'(c_rd_data);
        exp_rv = 1'b0; c_exp_rv = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            check_seq("rand", pos >= 0, (pos < 0) ? 0 : pos,
                      (pos < 0) ? 0 : ref_entry(pos, W, N), pos == N - 1);
            check("rand.rd_valid", longint'(rd_valid), longint'(exp_rv));
            if (exp_rv && exp_q.size() > 0) last_rd = longint'(exp_q.pop_front());
            check("rand.rd_data", longint'(rd_data), last_rd);
            check("rand.w24_rd_valid", longint'(c_rd_valid), longint'(c_exp_rv));
            if (c_exp_rv && c_exp_q.size() > 0) c_last_rd = longint'(c_exp_q.pop_front());
            check("rand.w24_rd_data", longint'(c_rd_data), c_last_rd);

            start   = ($urandom_range(0, 15) == 0);
            advance = $urandom_range(0, 1);
            rd_en   = $urandom_range(0, 1);
            rd_addr = IW'($urandom_range(0, N - 1));
            c_rd_en   = $urandom_range(0, 1);
            c_rd_addr = 5'($urandom_range(0, 31));

            if (start) pos = 0;
            else if (pos >= 0 && advance) pos = (pos == N - 1) ? -1 : pos + 1;
            exp_rv = rd_en;
            if (rd_en) begin
                e = 32'(ref_entry(int'(rd_addr), W, N));
                exp_q.push_back(e);
            end
            c_exp_rv = c_rd_en;
            if (c_rd_en) begin
                e = 32'(ref_entry(int'(c_rd_addr), 24, 24));
                c_exp_q.push_back(e);
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
